// File: rtl/z80_djnz_pkg.sv
// Shared types and constants for the DJNZ execution sequencer.
// Holds state enums, CYCLE_* codes, opcode and T-state counts.
package z80_djnz_pkg;

    // Top-level sequencer states. INT1..INT5 and DONE must stay
    // contiguous and in this order (the INT chain steps by +1).
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EXT,
        ST_READ,
        ST_INT1,
        ST_INT2,
        ST_INT3,
        ST_INT4,
        ST_INT5,
        ST_DONE
    } djnz_state_e;

    // Phases of the generic 3T memory read cycle.
    typedef enum logic [1:0] {
        RP_IDLE,
        RP_T1,
        RP_T2,
        RP_T3
    } rd_phase_e;

    // M-cycle type codes, same values as the core's z80 header.
    localparam logic [2:0] CYCLE_NONE     = 3'd0;
    localparam logic [2:0] CYCLE_M1       = 3'd1;
    localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;
    localparam logic [2:0] CYCLE_RDWR_IO  = 3'd3;
    localparam logic [2:0] CYCLE_INTERNAL = 3'd4;
    localparam logic [2:0] CYCLE_EXTENDED = 3'd5;

    localparam logic [7:0] OPC_DJNZ = 8'h10;

    // T-states per M-cycle.
    localparam int M1_T  = 4;
    localparam int EXT_T = 1;
    localparam int RD_T  = 3;
    localparam int INT_T = 5;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/z80_djnz_exec_mem_read.sv
// z80_mem_read_cycle: generic 3T memory read, T2 stretched by WAIT.
// Ports: go starts T1 next cycle; mem_rd high T1..T3; data latched at
// end of T3; last high during T3; wait_cnt counts T2 repeats (saturating).
module z80_mem_read_cycle #(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       wait_n,
    input  logic [7:0] rdata,
    output logic       mem_rd,
    output logic       last,
    output logic [7:0] data,
    output logic [7:0] wait_cnt
);
    import z80_djnz_pkg::*;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    rd_phase_e phase, phase_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase    <= RP_IDLE;
            data     <= 8'h00;
            wait_cnt <= 8'h00;
        end else begin
            phase <= phase_nx;
            if (go) begin
                wait_cnt <= 8'h00;
            end else if (phase == RP_T2 && !wait_n &&
                         wait_cnt != MAX_W) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (phase == RP_T3) begin
                data <= rdata;
            end
        end
    end

    always_comb begin
        phase_nx = phase;
        mem_rd   = 1'b1;
        last     = 1'b0;
        unique case (phase)
            RP_IDLE: begin
                mem_rd = 1'b0;
                if (go) phase_nx = RP_T1;
            end
            RP_T1: phase_nx = RP_T2;
            RP_T2: if (wait_n) phase_nx = RP_T3;
            RP_T3: begin
                last     = 1'b1;
                phase_nx = RP_IDLE;
            end
            default: phase_nx = RP_IDLE;
        endcase
    end

endmodule

// File: rtl/z80_djnz_exec.sv
// DJNZ e execution sequencer: EXT T-state, displacement read, optional
// 5T internal cycle, then B/IP writeback with a one-cycle done pulse.
// Ports: start/ip_in/b_in from decode; mem_* read bus with wait_n;
// mcycle/mcycle_type status; done with reg_b_out/reg_ip_out.
// Optional macro Z80_DJNZ_FI_RECORD_EN adds z80fi_* retirement outputs.
module z80_djnz_exec #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ip_in,
    input  logic [7:0]  b_in,
    output logic        busy,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        wait_n,
    output logic [2:0]  mcycle,
    output logic [2:0]  mcycle_type,
`ifdef Z80_DJNZ_FI_RECORD_EN
    output logic        z80fi_valid,
    output logic [7:0]  z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_bus_raddr,
    output logic [7:0]  z80fi_bus_rdata,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out,
    output logic [7:0]  z80fi_reg_b_in,
    output logic [7:0]  z80fi_reg_b_out,
    output logic [2:0]  z80fi_mcycle_type1,
    output logic [2:0]  z80fi_mcycle_type2,
    output logic [2:0]  z80fi_mcycle_type3,
    output logic [2:0]  z80fi_mcycle_type4,
    output logic [2:0]  z80fi_mcycle_type5,
    output logic [8:0]  z80fi_tcycles1,
    output logic [8:0]  z80fi_tcycles2,
    output logic [8:0]  z80fi_tcycles3,
    output logic [8:0]  z80fi_tcycles4,
`endif
    output logic        done,
    output logic [7:0]  reg_b_out,
    output logic [15:0] reg_ip_out
);
    import z80_djnz_pkg::*;

    djnz_state_e state, state_nx;

    logic [15:0] ip_lat;
    logic [7:0]  b_lat;
    logic        rd_go;
    logic        rd_last;
    logic [7:0]  rd_data;
    logic [7:0]  rd_waits;
    logic        taken;
    logic [7:0]  e_now;

    z80_mem_read_cycle #(
        .MAX_WAIT (MAX_WAIT)
    ) u_rd (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (rd_go),
        .wait_n   (wait_n),
        .rdata    (mem_rdata),
        .mem_rd   (mem_rd),
        .last     (rd_last),
        .data     (rd_data),
        .wait_cnt (rd_waits)
    );

    assign taken = (b_lat != 8'd1);

    // On the not-taken path DONE follows T3 directly, so the
    // displacement is taken from the bus before the latch updates.
    assign e_now = rd_last ? mem_rdata : rd_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ip_lat     <= 16'h0000;
            b_lat      <= 8'h00;
            mem_addr   <= 16'h0000;
            reg_b_out  <= 8'h00;
            reg_ip_out <= 16'h0000;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                ip_lat   <= ip_in;
                b_lat    <= b_in;
                mem_addr <= ip_in + 16'd1;
            end
            if (state_nx == ST_DONE) begin
                reg_b_out  <= b_lat - 8'd1;
                reg_ip_out <= ip_lat + 16'd2 +
                              (taken ? sext8(e_now) : 16'd0);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b1;
        done        = 1'b0;
        mcycle      = 3'd0;
        mcycle_type = CYCLE_NONE;
        rd_go       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_EXT;
            end
            ST_EXT: begin
                mcycle      = 3'd2;
                mcycle_type = CYCLE_EXTENDED;
                rd_go       = 1'b1;
                state_nx    = ST_READ;
            end
            ST_READ: begin
                mcycle      = 3'd3;
                mcycle_type = CYCLE_RDWR_MEM;
                if (rd_last) state_nx = taken ? ST_INT1 : ST_DONE;
            end
            ST_INT1, ST_INT2, ST_INT3, ST_INT4, ST_INT5: begin
                mcycle      = 3'd4;
                mcycle_type = CYCLE_INTERNAL;
                state_nx    = djnz_state_e'(state + 4'd1);
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef Z80_DJNZ_FI_RECORD_EN
    assign z80fi_valid        = done;
    assign z80fi_insn         = OPC_DJNZ;
    assign z80fi_insn_len     = 3'd1;
    assign z80fi_bus_raddr    = mem_addr;
    assign z80fi_bus_rdata    = rd_data;
    assign z80fi_reg_ip_in    = ip_lat;
    assign z80fi_reg_ip_out   = reg_ip_out;
    assign z80fi_reg_b_in     = b_lat;
    assign z80fi_reg_b_out    = reg_b_out;
    assign z80fi_mcycle_type1 = CYCLE_M1;
    assign z80fi_mcycle_type2 = CYCLE_EXTENDED;
    assign z80fi_mcycle_type3 = CYCLE_RDWR_MEM;
    assign z80fi_mcycle_type4 = taken ? CYCLE_INTERNAL : CYCLE_NONE;
    assign z80fi_mcycle_type5 = CYCLE_NONE;
    assign z80fi_tcycles1     = 9'(M1_T);
    assign z80fi_tcycles2     = 9'(EXT_T);
    assign z80fi_tcycles3     = 9'(RD_T) + {1'b0, rd_waits};
    assign z80fi_tcycles4     = taken ? 9'(INT_T) : 9'd0;
`else
    logic unused_waits;
    assign unused_waits = ^rd_waits;
`endif

endmodule

// File: tb/tb_z80_djnz_exec.sv
// Self-checking bench for z80_djnz_exec: per-cycle timeline model,
// directed vectors with literal pins, then randomized DJNZ streams.
module tb_z80_djnz_exec;
    import z80_djnz_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] ip_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        wait_n;
    logic [2:0]  mcycle;
    logic [2:0]  mcycle_type;
    logic        done;
    logic [7:0]  reg_b_out;
    logic [15:0] reg_ip_out;
`ifdef Z80_DJNZ_FI_RECORD_EN
    logic        fi_valid;
    logic [7:0]  fi_insn;
    logic [2:0]  fi_len;
    logic [15:0] fi_raddr;
    logic [7:0]  fi_rdata;
    logic [15:0] fi_ip_in, fi_ip_out;
    logic [7:0]  fi_b_in, fi_b_out;
    logic [2:0]  fi_mt1, fi_mt2, fi_mt3, fi_mt4, fi_mt5;
    logic [8:0]  fi_tc1, fi_tc2, fi_tc3, fi_tc4;
`endif

    always #5 clk = ~clk;

    z80_djnz_exec dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .ip_in       (ip_in),
        .b_in        (b_in),
        .busy        (busy),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .wait_n      (wait_n),
        .mcycle      (mcycle),
        .mcycle_type (mcycle_type),
`ifdef Z80_DJNZ_FI_RECORD_EN
        .z80fi_valid        (fi_valid),
        .z80fi_insn         (fi_insn),
        .z80fi_insn_len     (fi_len),
        .z80fi_bus_raddr    (fi_raddr),
        .z80fi_bus_rdata    (fi_rdata),
        .z80fi_reg_ip_in    (fi_ip_in),
        .z80fi_reg_ip_out   (fi_ip_out),
        .z80fi_reg_b_in     (fi_b_in),
        .z80fi_reg_b_out    (fi_b_out),
        .z80fi_mcycle_type1 (fi_mt1),
        .z80fi_mcycle_type2 (fi_mt2),
        .z80fi_mcycle_type3 (fi_mt3),
        .z80fi_mcycle_type4 (fi_mt4),
        .z80fi_mcycle_type5 (fi_mt5),
        .z80fi_tcycles1     (fi_tc1),
        .z80fi_tcycles2     (fi_tc2),
        .z80fi_tcycles3     (fi_tc3),
        .z80fi_tcycles4     (fi_tc4),
`endif
        .done        (done),
        .reg_b_out   (reg_b_out),
        .reg_ip_out  (reg_ip_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [7:0]  last_b;
    logic [15:0] last_ip;

    // Expected values for the current cycle, set by the driver.
    logic        chk_en = 1'b0;
    logic        x_busy, x_done, x_rd, x_zero, x_taken;
    logic [2:0]  x_mc, x_mt;
    logic [15:0] x_addr, x_ip, x_ipin;
    logic [7:0]  x_b, x_bin, x_e;
    logic [8:0]  x_tc3;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, x_busy);
            chk("mcycle", mcycle, x_mc);
            chk("mcycle_type", mcycle_type, x_mt);
            chk("done", done, x_done);
            chk("mem_rd", mem_rd, x_rd);
            if (x_rd) chk("mem_addr", mem_addr, x_addr);
            if (x_zero) begin
                chk("rst_addr", mem_addr, 0);
                chk("rst_b", reg_b_out, 0);
                chk("rst_ip", reg_ip_out, 0);
            end
            if (x_done) begin
                chk("reg_b_out", reg_b_out, x_b);
                chk("reg_ip_out", reg_ip_out, x_ip);
`ifdef Z80_DJNZ_FI_RECORD_EN
                chk("fi_valid", fi_valid, 1);
                chk("fi_insn", fi_insn, 8'h10);
                chk("fi_len", fi_len, 1);
                chk("fi_raddr", fi_raddr, x_addr);
                chk("fi_rdata", fi_rdata, x_e);
                chk("fi_ip_in", fi_ip_in, x_ipin);
                chk("fi_ip_out", fi_ip_out, x_ip);
                chk("fi_b_in", fi_b_in, x_bin);
                chk("fi_b_out", fi_b_out, x_b);
                chk("fi_mt1", fi_mt1, CYCLE_M1);
                chk("fi_mt2", fi_mt2, CYCLE_EXTENDED);
                chk("fi_mt3", fi_mt3, CYCLE_RDWR_MEM);
                chk("fi_mt4", fi_mt4,
                    x_taken ? CYCLE_INTERNAL : CYCLE_NONE);
                chk("fi_mt5", fi_mt5, CYCLE_NONE);
                chk("fi_tc1", fi_tc1, 4);
                chk("fi_tc2", fi_tc2, 1);
                chk("fi_tc3", fi_tc3, x_tc3);
                chk("fi_tc4", fi_tc4, x_taken ? 5 : 0);
`endif
            end
            if (done) begin
                done_cnt++;
                last_b  = reg_b_out;
                last_ip = reg_ip_out;
            end
        end
    end

    task automatic set_idle();
        x_busy = 1'b0;
        x_done = 1'b0;
        x_rd   = 1'b0;
        x_mc   = 3'd0;
        x_mt   = CYCLE_NONE;
    endtask

    task automatic noise_inputs();
        ip_in     = 16'($urandom);
        b_in      = 8'($urandom);
        mem_rdata = 8'($urandom);
        wait_n    = 1'($urandom);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
        noise_inputs();
        set_idle();
        chk_en = 1'b1;
    endtask

    // One DJNZ from the cycle start is driven (k=0) to its done cycle.
    // abort_k >= 0 pulls reset low during cycle abort_k.
    task automatic run_djnz(input logic [15:0] ip, input logic [7:0] b,
                            input logic [7:0] e, input int w,
                            input int abort_k, input bit noise);
        bit tk;
        int len;
        tk  = (b != 8'd1);
        len = tk ? 10 + w : 5 + w;
        for (int k = 0; k <= len; k++) begin
            @(posedge clk);
            #1;
            noise_inputs();
            start = noise && k >= 1 && ($urandom_range(0, 3) == 0);
            if (k == 0) begin
                start = 1'b1;
                ip_in = ip;
                b_in  = b;
            end
            if (k == 1) x_zero = 1'b0;
            if (k >= 3 && k < 3 + w) wait_n = 1'b0;
            if (k == 3 + w) wait_n = 1'b1;
            if (k == 4 + w) mem_rdata = e;
            x_busy  = (k >= 1);
            x_done  = (k == len);
            x_rd    = (k >= 2 && k <= 4 + w);
            x_addr  = ip + 16'd1;
            x_taken = tk;
            x_b     = b - 8'd1;
            x_ip    = ip + 16'd2 + (tk ? 16'($signed(e)) : 16'd0);
            x_ipin  = ip;
            x_bin   = b;
            x_e     = e;
            x_tc3   = 9'(3 + (w > 255 ? 255 : w));
            if (k == 0 || k == len) begin
                x_mc = 3'd0; x_mt = CYCLE_NONE;
            end else if (k == 1) begin
                x_mc = 3'd2; x_mt = CYCLE_EXTENDED;
            end else if (k <= 4 + w) begin
                x_mc = 3'd3; x_mt = CYCLE_RDWR_MEM;
            end else begin
                x_mc = 3'd4; x_mt = CYCLE_INTERNAL;
            end
            if (k == abort_k) begin
                reset_n = 1'b0;
                start   = 1'b0;
            end
            if (abort_k >= 0 && k == abort_k + 1) begin
                reset_n = 1'b1;
                start   = 1'b0;
                set_idle();
                x_zero  = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int d0;
        reset_n = 1'b0;
        start   = 1'b0;
        noise_inputs();
        x_zero = 1'b1;
        set_idle();
        repeat (3) idle_cycle();
        reset_n = 1'b1;
        idle_cycle();

        run_djnz(16'h1000, 8'd5, 8'hFE, 0, -1, 1'b0);
        idle_cycle();
        chk("pin1_b", last_b, 8'h04);
        chk("pin1_ip", last_ip, 16'h1000);

        run_djnz(16'h2000, 8'd1, 8'h10, 0, -1, 1'b0);
        idle_cycle();
        chk("pin2_b", last_b, 8'h00);
        chk("pin2_ip", last_ip, 16'h2002);

        run_djnz(16'hFFFE, 8'd0, 8'h7F, 0, -1, 1'b0);
        idle_cycle();
        chk("pin3_b", last_b, 8'hFF);
        chk("pin3_ip", last_ip, 16'h007F);

        run_djnz(16'h3000, 8'd3, 8'h05, 2, -1, 1'b0);
        idle_cycle();
        chk("pin4_ip", last_ip, 16'h3007);

        d0 = done_cnt;
        run_djnz(16'h4000, 8'd9, 8'h20, 0, 7, 1'b0);
        repeat (12) idle_cycle();
        chk("abort_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        run_djnz(16'h5000, 8'd2, 8'h80, 1, -1, 1'b1);
        run_djnz(16'h5100, 8'd1, 8'h33, 0, -1, 1'b1);
        idle_cycle();
        chk("b2b_done_cnt", done_cnt - d0, 2);
        chk("b2b_ip", last_ip, 16'h5102);

        run_djnz(16'h6000, 8'd7, 8'h01, 260, -1, 1'b0);
        idle_cycle();

        d0 = done_cnt;
        for (int t = 0; t < 60; t++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 1));
            run_djnz(16'($urandom), rb, 8'($urandom),
                     $urandom_range(0, 3), -1, 1'b1);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        chk("rand_done_cnt", done_cnt - d0, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_djnz_exec.md
Name: z80_djnz_exec

Overview:
- Execution-side sequencer for DJNZ e (opcode 0x10). It produces the bus and M-cycle activity, and the retirement record, that the DJNZ formal spec checks.
- Takes over after the core's M1 opcode fetch/decode.
- Timing: one extended T-state, then a 3T memory read of the displacement at IP+1 (WAIT-extendable), then a 5T internal cycle when the branch is taken.
- Writes back B and IP, then returns control to the core sequencer.

Parameters:
- MAX_WAIT, 255, saturation limit of the wait-state count added to M3 tcycles.

Ports:
- clk  in  1  T-state clock; one clk = one T-state
- reset_n  in  1  synchronous active-low reset
- start  in  1  pulse in M1 T4 when decoder sees opcode 0x10
- ip_in  in  16  address of the DJNZ opcode
- b_in  in  8  B register value at M1
- busy  out  1  high from cycle after start until done
- mem_rd  out  1  memory read strobe, high during M3 T1..T3
- mem_addr  out  16  read address, ip_in+1
- mem_rdata  in  8  read data, sampled at M3 T3
- wait_n  in  1  active-low WAIT, sampled in M3 T2
- mcycle  out  3  current M-cycle index (2..4), 0 when idle
- mcycle_type  out  3  CYCLE_* code of current M-cycle
- done  out  1  one-cycle pulse when writeback is valid
- reg_b_out  out  8  b_in-1, valid with done
- reg_ip_out  out  16  new IP, valid with done

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE.
  - busy, mem_rd, done, mcycle are 0; mcycle_type is CYCLE_NONE.
  - mem_addr, reg_b_out and reg_ip_out are 0.
  - Reset mid-instruction aborts with no done and no record.
- States: IDLE -> EXT -> RD_T1 -> RD_T2 -> RD_T3 -> (INT1..INT5 if taken) -> DONE -> IDLE.
- IDLE + start:
  - Latch ip_in and b_in.
  - Next cycle is EXT, with mcycle=2, type CYCLE_EXTENDED.
  - start is ignored while busy.
- EXT:
  - Lasts 1 cycle.
  - mem_addr = ip_in+1 (16-bit wrap, 0xFFFF -> 0x0000).
- RD_T1..RD_T3:
  - mcycle=3, type CYCLE_RDWR_MEM, mem_rd high.
  - RD_T2 repeats while wait_n is sampled low; each repeat adds 1 to the wait count, saturating at MAX_WAIT.
  - mem_rdata is latched as e at the end of RD_T3.
- Branch decision:
  - taken = (b_latched != 1).
  - b_latched = 0 is taken; reg_b_out wraps to 0xFF.
- Taken: INT1..INT5, mcycle=4, type CYCLE_INTERNAL, 5 cycles.
- Not taken: RD_T3 goes directly to DONE.
- Arithmetic:
  - reg_b_out = b_latched - 1 (mod 256).
  - reg_ip_out = ip_latched + 2 + (taken ? sign-extend16(e) : 0), mod 2^16.
- DONE:
  - done=1 for exactly one cycle, with reg_b_out and reg_ip_out valid.
  - busy drops in the following cycle.
  - start may be accepted in that following cycle (back-to-back DJNZ).
- Latency from start to done, with W = wait states:
  - Taken: 10+W cycles.
  - Not taken: 5+W cycles.

Optional Feature:
- Macro: Z80_DJNZ_FI_RECORD_EN.
- Defined: adds outputs valid with done:
  - z80fi_valid.
  - z80fi_insn=0x10 and insn_len=1.
  - bus_raddr/bus_rdata.
  - reg_ip_in/out and reg_b_in/out.
  - mcycle_type1..5 = M1, EXTENDED, RDWR_MEM, INTERNAL or NONE, NONE.
  - tcycles1..4 = 4, 1, 3+W, 5.
  - tcycles4 is 5 when taken and 0 when not taken.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package z80_djnz_pkg holds:
  - State enum.
  - CYCLE_* codes, shared with the existing z80 header values.
  - OPC_DJNZ = 8'h10.
  - T-state count constants: EXT_T=1, RD_T=3, INT_T=5.
- Natural sub-module: z80_mem_read_cycle.
  - Generic 3T read with WAIT stretching.
  - Outputs mem_rd, data latch and a done strobe.
  - Reused by other instructions that read memory.

Test Plan:
- ip_in=0x1000, b_in=5, e=0xFE, wait_n=1 -> done at start+10; reg_b_out=4; reg_ip_out=0x1000; mem_addr=0x1001 for 3 cycles.
- ip_in=0x2000, b_in=1, e=0x10 -> not taken; done at start+5; reg_b_out=0; reg_ip_out=0x2002; no INT cycles.
- b_in=0, ip_in=0xFFFE, e=0x7F -> reg_b_out=0xFF; reg_ip_out=0x007F (wrap); mem_addr=0xFFFF.
- wait_n low for 2 RD_T2 samples, taken -> done at start+12; with FI_RECORD_EN, tcycles3=5.
- reset_n low during INT3 -> next cycle busy=0, done=0, mcycle=0; no done pulse follows.
- Back-to-back: second start in the cycle after done -> accepted; start pulsed while busy is ignored (exactly one done).
